// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and stall controller for a 5-stage in-order pipeline.
//   - Freezes the whole pipeline while a data-memory access is outstanding.
//     A watchdog moves the controller to HALT, with a sticky err, if the
//     acknowledge never arrives.
//   - Inserts a one-cycle bubble for load-use hazards. Without forwarding,
//     it also stalls for any read-after-write dependency still in flight.
//   - Flushes IF/ID, ID/EX and EX/MEM when a branch resolves taken in MEM.
//   - Selects the ALU operand forwarding sources (only with FWD_EN).
//
// Configuration macro: FWD_EN
//   defined   : forwarding enabled; only load-use hazards stall.
//   undefined : fwd_a/fwd_b stay 00; every in-flight RAW dependency stalls.
//
// Ports
//   CLK, RST                     clock (rising edge), synchronous active-high reset
//   id_rs, id_rt, id_uses_rt     source fields of the instruction in ID
//   ex_rs, ex_rt, ex_rd          EX-stage register fields
//   ex_rw, ex_mread              EX register write / load
//   mem_rd, mem_rw, wb_rd, wb_rw destination register and write enable in MEM / WB
//   br_taken                     taken branch resolved in MEM
//   dmem_req, dmem_ack           data-memory access in MEM / completes this cycle
//   pc_en .. memwb_en            stage-register enables
//   ifid_flush .. exmem_flush    load a NOP into the register at the next edge
//   fwd_a, fwd_b                 operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt                    saturating count of bubble/freeze cycles
//   err                          sticky DMem timeout flag
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TMO = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rw,
  input  logic        ex_mread,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_rw,
  input  logic        wb_rw,
  input  logic        br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic        err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  // The last MWAIT cycle: the counter starts at 0, so TMO-1 marks TMO cycles.
  localparam logic [3:0] WAIT_LAST = 4'(TMO - 1);

  state_t      stateReg;
  logic [3:0]  waitCntReg;
  logic [15:0] stallCntReg;
  logic        errReg;

  logic        freeze;
  logic        hazard;
  logic        bubble;

  // ---------------------------------------------------------------------------
  // Producer stages that may write a register the ID instruction reads.
  // Index 0 = EX, 1 = MEM, 2 = WB. Register 0 is never a dependency.
  // ---------------------------------------------------------------------------
  logic [2:0][4:0] prodRd;
  logic [2:0]      prodRw;
  logic [2:0]      prodMatch;

  assign prodRd = {wb_rd, mem_rd, ex_rd};
  assign prodRw = {wb_rw, mem_rw, ex_rw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_prod
      assign prodMatch[gi] = (prodRd[gi] != 5'd0) &&
                             ((prodRd[gi] == id_rs) ||
                              (id_uses_rt && (prodRd[gi] == id_rt)));
    end
  endgenerate

`ifdef FWD_EN
  // Forwarding covers every ALU result; only a load's data arrives too late.
  assign hazard = ex_mread && prodMatch[0];
`else
  // The register file is not write-through, so even a WB-stage writer
  // must drain before ID can read the register.
  assign hazard = (ex_mread && prodMatch[0]) || (|(prodRw & prodMatch));
`endif

  // ---------------------------------------------------------------------------
  // Forwarding select, operand 0 = A (ex_rs), operand 1 = B (ex_rt).
  // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
  // ---------------------------------------------------------------------------
  logic [1:0][1:0] fwdSel;

`ifdef FWD_EN
  logic [1:0][4:0] opSrc;
  logic [1:0]      memHit;
  logic [1:0]      wbHit;

  assign opSrc = {ex_rt, ex_rs};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign memHit[gi] = mem_rw && (mem_rd != 5'd0) && (mem_rd == opSrc[gi]);
      assign wbHit[gi]  = wb_rw  && (wb_rd  != 5'd0) && (wb_rd  == opSrc[gi]);
      assign fwdSel[gi] = RST        ? 2'b00 :
                          memHit[gi] ? 2'b10 :
                          wbHit[gi]  ? 2'b01 : 2'b00;
    end
  endgenerate
`else
  // The EX source fields only matter when forwarding is built in.
  logic unusedFwdSrc;
  assign unusedFwdSrc = ^{ex_rs, ex_rt};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwdSel[gi] = 2'b00;
    end
  endgenerate
`endif

  assign fwd_a = fwdSel[0];
  assign fwd_b = fwdSel[1];

  // A pending access freezes the pipe in the very cycle it is requested.
  // The cycle the ack arrives is not frozen: the pipe advances, and a branch
  // or stall held through the freeze takes effect then.
  assign freeze = !dmem_ack &&
                  ((stateReg == MWAIT) || ((stateReg == RUN) && dmem_req));

  // ---------------------------------------------------------------------------
  // Stage control, in priority order: reset, halt, freeze, branch, stall.
  // A taken branch squashes the dependent ID instruction, so no stall occurs.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    bubble      = 1'b0;
    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if ((stateReg == HALT) || freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      bubble   = (stateReg != HALT);
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      bubble     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-wait FSM, watchdog, bubble counter and sticky error.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg    <= RUN;
      waitCntReg  <= 4'd0;
      stallCntReg <= 16'd0;
      errReg      <= 1'b0;
    end else begin
      if (bubble && (stallCntReg != 16'hFFFF)) begin
        stallCntReg <= stallCntReg + 16'd1;
      end
      case (stateReg)
        RUN: begin
          if (dmem_req && !dmem_ack) begin
            stateReg   <= MWAIT;
            waitCntReg <= 4'd0;
          end
        end
        MWAIT: begin
          if (dmem_ack) begin
            stateReg <= RUN;
          end else if (waitCntReg == WAIT_LAST) begin
            stateReg <= HALT;
            errReg   <= 1'b1;
          end else begin
            waitCntReg <= waitCntReg + 4'd1;
          end
        end
        HALT: begin
          errReg <= 1'b1;
        end
        default: begin
          stateReg <= RUN;
        end
      endcase
    end
  end

  assign stall_cnt = stallCntReg;
  assign err       = errReg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scenarios for reset, load-use stall, branch flush, memory wait,
//   timeout and forwarding, followed by randomized cycles checked against a
//   behavioural model of the controller rules. Works with and without FWD_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rt, ex_rw, ex_mread, mem_rw, wb_rw;
  logic        br_taken, dmem_req, dmem_ack;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic        err;

  logic [4:0]  en;
  logic [2:0]  fl;
  assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  assign fl = {ifid_flush, idex_flush, exmem_flush};

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit mWaiting, mHalted, mErr;
  int mWait, mStall;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.TMO(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_mread(ex_mread),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_rw(mem_rw), .wb_rw(wb_rw),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .err(err)
  );

  // ---------------------------------------------------------------------------
  // Stimulus plumbing
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_rw = 0; ex_mread = 0;
    mem_rd = 0; wb_rd = 0; mem_rw = 0; wb_rw = 0;
    br_taken = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // From posedge+1 to the falling edge, where outputs are sampled.
  task automatic settle();
    #4;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    next_cycle();
    RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit readsOf(input logic [4:0] r);
    return (r != 5'd0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
  endfunction

  function automatic bit hazardRef();
    bit h;
    h = ex_mread && readsOf(ex_rd);
`ifndef FWD_EN
    h = h || (ex_rw && readsOf(ex_rd)) || (mem_rw && readsOf(mem_rd)) ||
         (wb_rw && readsOf(wb_rd));
`endif
    return h;
  endfunction

  // Newest writer wins: MEM-stage result is younger than WB-stage result.
  function automatic logic [1:0] fwdRef(input logic [4:0] src);
    logic [1:0] r;
    r = 2'b00;
    if (!RST && (src != 5'd0)) begin
`ifdef FWD_EN
      if (wb_rw && (wb_rd == src)) r = 2'b01;
      if (mem_rw && (mem_rd == src)) r = 2'b10;
`endif
    end
    return r;
  endfunction

  task automatic model_expect(output logic [4:0] eEn, output logic [2:0] eFl,
                              output bit eBub);
    eBub = 1'b0;
    if (RST) begin
      eEn = 5'b11111; eFl = 3'b111;
    end else if (mHalted) begin
      eEn = 5'b00000; eFl = 3'b000;
    end else if (!dmem_ack && (mWaiting || dmem_req)) begin
      eEn = 5'b00000; eFl = 3'b000; eBub = 1'b1;
    end else if (br_taken) begin
      eEn = 5'b11111; eFl = 3'b111;
    end else if (hazardRef()) begin
      eEn = 5'b00111; eFl = 3'b010; eBub = 1'b1;
    end else begin
      eEn = 5'b11111; eFl = 3'b000;
    end
  endtask

  task automatic model_step(input bit bub);
    if (RST) begin
      mWaiting = 0; mHalted = 0; mErr = 0; mWait = 0; mStall = 0;
    end else begin
      if (bub && (mStall < 65535)) mStall++;
      if (mHalted) begin
        // stays halted until reset
      end else if (mWaiting) begin
        if (dmem_ack) begin
          mWaiting = 0;
        end else begin
          mWait++;
          if (mWait == TMO) begin
            mHalted = 1; mErr = 1; mWaiting = 0;
          end
        end
      end else if (dmem_req && !dmem_ack) begin
        mWaiting = 1; mWait = 0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    // Inputs that would otherwise freeze, branch, stall and forward.
    dmem_req = 1; br_taken = 1; ex_mread = 1; ex_rw = 1; ex_rd = 2; id_rs = 2;
    ex_rs = 5; mem_rd = 5; mem_rw = 1;
    next_cycle();
    settle();
    total++;
    if (en !== 5'b11111 || fl !== 3'b111) begin
      bad++; $display("FAIL reset_ctl en/fl got %b/%b want 11111/111", en, fl);
    end
    total++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      bad++; $display("FAIL reset_fwd got %b/%b want 00/00", fwd_a, fwd_b);
    end
    total++;
    if (stall_cnt !== 16'd0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_regs cnt/err got %0d/%b want 0/0", stall_cnt, err);
    end
    $display("reset: held en=%b fl=%b fa=%b cnt=%0d err=%b", en, fl, fwd_a, stall_cnt, err);
    next_cycle();
    RST = 1'b0;
    clear_inputs();
    settle();
    total++;
    if (en !== 5'b11111 || fl !== 3'b000 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_release en/fl/cnt got %b/%b/%0d want 11111/000/0",
                      en, fl, stall_cnt);
    end
    $display("reset: released en=%b fl=%b cnt=%0d", en, fl, stall_cnt);
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [4:0] rdT [4] = '{5'd2, 5'd2, 5'd2, 5'd0};
    logic [4:0] rsT [4] = '{5'd2, 5'd4, 5'd4, 5'd0};
    logic [4:0] rtT [4] = '{5'd3, 5'd2, 5'd2, 5'd0};
    bit         urT [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit         stT [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         cnT [4] = '{1, 1, 2, 2};
    logic [4:0] eEn;
    logic [2:0] eFl;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      ex_mread = 1; ex_rw = 1; ex_rd = rdT[i];
      id_rs = rsT[i]; id_rt = rtT[i]; id_uses_rt = urT[i];
      settle();
      eEn = stT[i] ? 5'b00111 : 5'b11111;
      eFl = stT[i] ? 3'b010 : 3'b000;
      total++;
      if (en !== eEn || fl !== eFl) begin
        bad++; $display("FAIL load_use[%0d] en/fl got %b/%b want %b/%b", i, en, fl, eEn, eFl);
      end
      next_cycle();
      total++;
      if (stall_cnt !== 16'(cnT[i])) begin
        bad++; $display("FAIL load_use_cnt[%0d] got %0d want %0d", i, stall_cnt, cnT[i]);
      end
      $display("load_use[%0d]: rd=%0d rs=%0d rt=%0d urt=%b en=%b fl=%b cnt=%0d",
               i, rdT[i], rsT[i], rtT[i], urT[i], eEn, eFl, stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    clear_inputs();
    ex_mread = 1; ex_rw = 1; ex_rd = 2; id_rs = 2; br_taken = 1;
    settle();
    total++;
    if (en !== 5'b11111 || fl !== 3'b111) begin
      bad++; $display("FAIL branch_over_stall en/fl got %b/%b want 11111/111", en, fl);
    end
    next_cycle();
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++; $display("FAIL branch_cnt got %0d want 0", stall_cnt);
    end
    $display("branch: flush during load-use en=%b cnt=%0d", en, stall_cnt);
    br_taken = 0;
    settle();
    total++;
    if (en !== 5'b00111 || fl !== 3'b010) begin
      bad++; $display("FAIL branch_then_stall en/fl got %b/%b want 00111/010", en, fl);
    end
    next_cycle();
    total++;
    if (stall_cnt !== 16'd1) begin
      bad++; $display("FAIL branch_then_stall_cnt got %0d want 1", stall_cnt);
    end
    $display("branch: stall afterwards en=%b cnt=%0d", en, stall_cnt);
  endtask

  task automatic test_mem_wait();
    do_reset();
    clear_inputs();
    br_taken = 1;
    for (int k = 0; k < 4; k++) begin
      // Request dropped in the last wait cycle: the wait state alone holds the freeze.
      dmem_req = (k != 3);
      dmem_ack = 0;
      settle();
      total++;
      if (en !== 5'b00000 || fl !== 3'b000) begin
        bad++; $display("FAIL mem_freeze[%0d] en/fl got %b/%b want 00000/000", k, en, fl);
      end
      $display("mem_wait[%0d]: en=%b fl=%b", k, en, fl);
      next_cycle();
    end
    dmem_req = 1; dmem_ack = 1;
    settle();
    total++;
    if (en !== 5'b11111 || fl !== 3'b111) begin
      bad++; $display("FAIL mem_ack_branch en/fl got %b/%b want 11111/111", en, fl);
    end
    next_cycle();
    total++;
    if (stall_cnt !== 16'd4) begin
      bad++; $display("FAIL mem_wait_cnt got %0d want 4", stall_cnt);
    end
    $display("mem_wait: ack en=%b fl=%b cnt=%0d", en, fl, stall_cnt);
    clear_inputs();
    dmem_req = 1; dmem_ack = 1;
    settle();
    total++;
    if (en !== 5'b11111 || fl !== 3'b000) begin
      bad++; $display("FAIL mem_same_cycle_ack en/fl got %b/%b want 11111/000", en, fl);
    end
    next_cycle();
    total++;
    if (stall_cnt !== 16'd4) begin
      bad++; $display("FAIL mem_same_cycle_cnt got %0d want 4", stall_cnt);
    end
    $display("mem_wait: immediate ack en=%b cnt=%0d", en, stall_cnt);
  endtask

  task automatic test_timeout();
    do_reset();
    clear_inputs();
    dmem_req = 1;
    for (int k = 0; k <= TMO; k++) begin
      settle();
      total++;
      if (en !== 5'b00000 || err !== 1'b0) begin
        bad++; $display("FAIL tmo_wait[%0d] en/err got %b/%b want 00000/0", k, en, err);
      end
      next_cycle();
    end
    dmem_ack = 1;
    settle();
    total++;
    if (err !== 1'b1 || en !== 5'b00000 || fl !== 3'b000) begin
      bad++; $display("FAIL tmo_halt err/en/fl got %b/%b/%b want 1/00000/000", err, en, fl);
    end
    $display("timeout: halted err=%b en=%b", err, en);
    next_cycle();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL tmo_sticky err got %b want 1", err);
    end
    RST = 1'b1;
    clear_inputs();
    settle();
    total++;
    if (en !== 5'b11111 || fl !== 3'b111) begin
      bad++; $display("FAIL tmo_rst_ctl en/fl got %b/%b want 11111/111", en, fl);
    end
    next_cycle();
    RST = 1'b0;
    settle();
    total++;
    if (err !== 1'b0 || en !== 5'b11111 || fl !== 3'b000 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL tmo_recover err/en/fl/cnt got %b/%b/%b/%0d want 0/11111/000/0",
                      err, en, fl, stall_cnt);
    end
    $display("timeout: after reset err=%b en=%b cnt=%0d", err, en, stall_cnt);
    next_cycle();
  endtask

  task automatic test_forwarding();
`ifdef FWD_EN
    logic [4:0] mRdT [4] = '{5'd5, 5'd0, 5'd5, 5'd6};
    bit         mRwT [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] wRdT [4] = '{5'd5, 5'd5, 5'd0, 5'd5};
    logic [4:0] rtT  [4] = '{5'd6, 5'd5, 5'd5, 5'd6};
    logic [1:0] aT   [4] = '{2'b10, 2'b01, 2'b00, 2'b01};
    logic [1:0] bT   [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      ex_rs = 5; ex_rt = rtT[i]; id_rs = 5;
      mem_rd = mRdT[i]; mem_rw = mRwT[i]; wb_rd = wRdT[i]; wb_rw = 1;
      settle();
      total++;
      if (fwd_a !== aT[i] || fwd_b !== bT[i]) begin
        bad++; $display("FAIL fwd[%0d] a/b got %b/%b want %b/%b", i, fwd_a, fwd_b, aT[i], bT[i]);
      end
      total++;
      if (en !== 5'b11111) begin
        bad++; $display("FAIL fwd_nostall[%0d] en got %b want 11111", i, en);
      end
      $display("fwd[%0d]: mem=%0d/%b wb=%0d a=%b b=%b en=%b",
               i, mRdT[i], mRwT[i], wRdT[i], fwd_a, fwd_b, en);
      next_cycle();
    end
`else
    logic [4:0] exRdT [5] = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0};
    bit         exRwT [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] mRdT  [5] = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
    bit         mRwT  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit         wRwT  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0] wRdT  [5] = '{5'd3, 5'd3, 5'd0, 5'd0, 5'd0};
    logic [4:0] rsT   [5] = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd0};
    logic [4:0] rtT   [5] = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
    bit         stT   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] eEn;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      ex_rs = 3; ex_rt = 3;
      ex_rd = exRdT[i]; ex_rw = exRwT[i]; mem_rd = mRdT[i]; mem_rw = mRwT[i];
      wb_rd = wRdT[i]; wb_rw = wRwT[i];
      id_rs = rsT[i]; id_rt = rtT[i]; id_uses_rt = 1;
      settle();
      eEn = stT[i] ? 5'b00111 : 5'b11111;
      total++;
      if (en !== eEn) begin
        bad++; $display("FAIL nofwd_stall[%0d] en got %b want %b", i, en, eEn);
      end
      total++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
        bad++; $display("FAIL nofwd_sel[%0d] a/b got %b/%b want 00/00", i, fwd_a, fwd_b);
      end
      $display("nofwd[%0d]: ex=%0d mem=%0d wb=%0d/%b en=%b a=%b",
               i, exRdT[i], mRdT[i], wRdT[i], wRwT[i], en, fwd_a);
      next_cycle();
    end
`endif
  endtask

  task automatic test_random();
    logic [4:0] eEn;
    logic [2:0] eFl;
    logic [1:0] eA, eB;
    bit         eBub;
    do_reset();
    mWaiting = 0; mHalted = 0; mErr = 0; mWait = 0; mStall = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      RST        = ($urandom_range(0, 49) == 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_rs      = 5'($urandom_range(0, 3));
      ex_rt      = 5'($urandom_range(0, 3));
      ex_rd      = 5'($urandom_range(0, 3));
      ex_rw      = 1'($urandom_range(0, 1));
      ex_mread   = ($urandom_range(0, 2) == 0);
      mem_rd     = 5'($urandom_range(0, 3));
      mem_rw     = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 3));
      wb_rw      = 1'($urandom_range(0, 1));
      br_taken   = ($urandom_range(0, 5) == 0);
      dmem_req   = ($urandom_range(0, 7) == 0);
      dmem_ack   = ($urandom_range(0, 3) == 0);
      model_expect(eEn, eFl, eBub);
      eA = fwdRef(ex_rs);
      eB = fwdRef(ex_rt);
      settle();
      total++;
      if (en !== eEn || fl !== eFl) begin
        bad++; $display("FAIL rand_ctl[%0d] en/fl got %b/%b want %b/%b", cyc, en, fl, eEn, eFl);
      end
      total++;
      if (fwd_a !== eA || fwd_b !== eB) begin
        bad++; $display("FAIL rand_fwd[%0d] a/b got %b/%b want %b/%b", cyc, fwd_a, fwd_b, eA, eB);
      end
      model_step(eBub);
      next_cycle();
      total++;
      if (stall_cnt !== 16'(mStall) || err !== mErr) begin
        bad++; $display("FAIL rand_regs[%0d] cnt/err got %0d/%b want %0d/%b",
                        cyc, stall_cnt, err, mStall, mErr);
      end
      $display("rand[%0d]: rst=%b req=%b ack=%b br=%b en=%b fl=%b a=%b b=%b cnt=%0d err=%b",
               cyc, RST, dmem_req, dmem_ack, br_taken, eEn, eFl, eA, eB, mStall, mErr);
    end
    RST = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
